// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and helpers for the SIPO deserializer slice.
//               - sipo_state_t : deserializer FSM state encoding
//               - DEF_DATA_W   : default parallel word width
//               - cnt_width()  : bit-counter width, never less than 1
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  localparam int DEF_DATA_W = 8;

  // Width needed to count 0..w-1; a width of 1 is kept for tiny words so
  // that the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : sipo_bit_counter
// Description : Modulo-DATA_W bit counter with enable and synchronous clear.
// Ports       : clk      in   clock, rising edge
//               rst_n    in   asynchronous active-low reset
//               en_i     in   count one bit this cycle
//               clear_i  in   return count to zero (has priority over en_i)
//               count_o  out  current count, 0..DATA_W-1
//               last_o   out  en_i while count_o == DATA_W-1 (wraps this edge)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign last_o  = en_i & (count_q == C_MAX);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : (count_q + C_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in / parallel-out front stage. Collects DATA_W bits
//               qualified by s_en into a word and presents it on a one-entry
//               valid/ready output register. Flags aborted and dropped words.
// Ports       : clk         in   clock, rising edge
//               rst_n       in   asynchronous active-low reset
//               s_en        in   serial enable, one bit sampled per edge
//               s_data      in   serial data bit
//               p_data      out  parallel word held in the output register
//               p_valid     out  output register holds an unconsumed word
//               p_ready     in   downstream accepts (transfer on valid&ready)
//               word_done   out  pulse the cycle after a word's last bit
//               frame_abort out  pulse after s_en drops mid-word
//               overflow    out  sticky: a completed word was dropped
//               ovf_clr     in   synchronous clear of overflow
//               bit_cnt     out  bits collected so far (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,  // must be >= 2
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_en,
  input  logic                          s_data,
  output logic [DATA_W-1:0]             p_data,
  output logic                          p_valid,
  input  logic                          p_ready,
  output logic                          word_done,
  output logic                          frame_abort,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [cnt_width(DATA_W)-1:0]  bit_cnt
);

  localparam int CNT_W = cnt_width(DATA_W);

  sipo_state_t       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] p_data_q, p_data_d;
  logic              p_valid_q, p_valid_d;
  logic              word_done_q;
  logic              frame_abort_q;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] w_shift_in;
  logic [CNT_W-1:0]  w_count;
  logic              w_last;
  logic              w_abort;
  logic              w_drop;

  // --------------------------------------------------------------------------
  // Bit counter; cleared only when a partial word is abandoned, otherwise it
  // wraps by itself on the last bit.
  // --------------------------------------------------------------------------
  sipo_bit_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (s_en),
    .clear_i (w_abort),
    .count_o (w_count),
    .last_o  (w_last)
  );

  // --------------------------------------------------------------------------
  // Shift direction. w_shift_in is the register contents including the bit
  // sampled this edge, so on the last bit it is the finished word.
  // --------------------------------------------------------------------------
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_shift_in = {shift_q[DATA_W-2:0], s_data};
  end else begin : g_lsb_first
    assign w_shift_in = {s_data, shift_q[DATA_W-1:1]};
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    w_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_en) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!s_en) begin
          state_d = IDLE;
          w_abort = 1'b1;
        end else if (w_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  // A completed word is lost only when the output register is full and is
  // not being drained in the same cycle.
  assign w_drop = w_last & p_valid_q & ~p_ready;

  always_comb begin
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    p_valid_d  = p_valid_q;
    overflow_d = overflow_q;

    if (w_abort) begin
      shift_d = '0;
    end else if (s_en) begin
      shift_d = w_shift_in;
    end

    if (w_last && !w_drop) begin
      p_data_d  = w_shift_in;
      p_valid_d = 1'b1;
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end

    // A new drop beats a coincident clear.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      p_data_q      <= '0;
      p_valid_q     <= 1'b0;
      word_done_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      p_valid_q     <= p_valid_d;
      word_done_q   <= w_last;
      frame_abort_q <= w_abort;
      overflow_q    <= overflow_d;
    end
  end

  assign p_data      = p_data_q;
  assign p_valid     = p_valid_q;
  assign word_done   = word_done_q;
  assign frame_abort = frame_abort_q;
  assign overflow    = overflow_q;
  assign bit_cnt     = w_count;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Self-checking bench for sipo_deserializer. Two instances share
//               all inputs: m_* is MSB-first, l_* is LSB-first. Expected
//               MSB-first words are queued when their bits are driven and
//               compared when the word appears on the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       s_en    = 1'b0;
  logic       s_data  = 1'b0;
  logic       p_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [7:0] m_p_data, l_p_data;
  logic       m_p_valid, l_p_valid;
  logic       m_word_done, l_word_done;
  logic       m_frame_abort, l_frame_abort;
  logic       m_overflow, l_overflow;
  logic [2:0] m_bit_cnt, l_bit_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.DATA_W(8), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .s_en(s_en), .s_data(s_data),
    .p_data(m_p_data), .p_valid(m_p_valid), .p_ready(p_ready),
    .word_done(m_word_done), .frame_abort(m_frame_abort),
    .overflow(m_overflow), .ovf_clr(ovf_clr), .bit_cnt(m_bit_cnt)
  );

  sipo_deserializer #(.DATA_W(8), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_en(s_en), .s_data(s_data),
    .p_data(l_p_data), .p_valid(l_p_valid), .p_ready(p_ready),
    .word_done(l_word_done), .frame_abort(l_frame_abort),
    .overflow(l_overflow), .ovf_clr(ovf_clr), .bit_cnt(l_bit_cnt)
  );

  // The LSB-first instance sees the same serial stream, so its word is the
  // bit-reverse of the MSB-first word.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Inputs change on the falling edge; outputs are read on the falling edge.
  task automatic drive_bit(input logic b);
    s_en   = 1'b1;
    s_data = b;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_p_data, m_p_valid, m_word_done, m_frame_abort, m_overflow, m_bit_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_msb outputs got %h/%b/%b/%b/%b/%0d want all zero",
               m_p_data, m_p_valid, m_word_done, m_frame_abort, m_overflow, m_bit_cnt);
    end
    checks++;
    if ({l_p_data, l_p_valid, l_word_done, l_frame_abort, l_overflow, l_bit_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_lsb outputs got %h/%b/%b/%b/%b/%0d want all zero",
               l_p_data, l_p_valid, l_word_done, l_frame_abort, l_overflow, l_bit_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_msb_word();
    logic [7:0] w;
    int         wd;
    w  = 8'hA5;
    wd = 0;
    p_ready = 1'b1;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i]);
      wd += int'(m_word_done);
    end
    s_en = 1'b0;
    checks++;
    if (m_p_valid !== 1'b1) begin
      errors++; $display("FAIL msb_valid got %b want 1", m_p_valid);
    end
    checks++;
    if (sb_q.size() == 0 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL msb_data got %h want %h", m_p_data, w);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    checks++;
    if (m_bit_cnt !== 3'd0) begin
      errors++; $display("FAIL msb_bitcnt_wrap got %0d want 0", m_bit_cnt);
    end
    @(negedge clk);
    wd += int'(m_word_done);
    checks++;
    if (wd !== 1) begin
      errors++; $display("FAIL msb_word_done_count got %0d want 1", wd);
    end
    checks++;
    if (m_p_valid !== 1'b0 || m_p_data !== 8'hA5) begin
      errors++; $display("FAIL msb_transfer got valid=%b data=%h want valid=0 data=a5", m_p_valid, m_p_data);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] bits;
    logic [7:0] w;
    // Serial order 1,0,1,0,0,1,0,1 (first bit is bits[7]).
    bits = 8'b1010_0101;
    p_ready = 1'b1;
    sb_q.push_back(bits);
    for (int i = 7; i >= 0; i--) drive_bit(bits[i]);
    s_en = 1'b0;
    checks++;
    if (l_p_valid !== 1'b1 || l_p_data !== 8'hA5) begin
      errors++; $display("FAIL lsb_a5 got valid=%b data=%h want valid=1 data=a5", l_p_valid, l_p_data);
    end
    checks++;
    if (sb_q.size() == 0 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL lsb_pass_msb_data got %h want %h", m_p_data, bits);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
    // Non-palindromic pattern: 0x12 MSB-first lands as 0x48 LSB-first.
    w = 8'h12;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    s_en = 1'b0;
    checks++;
    if (l_p_data !== rev8(w)) begin
      errors++; $display("FAIL lsb_12 got %h want %h", l_p_data, rev8(w));
    end
    checks++;
    if (sb_q.size() == 0 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL msb_12 got %h want %h", m_p_data, w);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_back_to_back_overflow();
    logic [15:0] seq;
    int          wd;
    seq = 16'h3CF0;
    wd  = 0;
    p_ready = 1'b0;
    sb_q.push_back(8'h3C);  // 0xF0 is expected to be dropped
    for (int i = 15; i >= 0; i--) begin
      drive_bit(seq[i]);
      wd += int'(m_word_done);
      if (i == 8) begin
        checks++;
        if (m_p_valid !== 1'b1 || m_p_data !== 8'h3C) begin
          errors++; $display("FAIL b2b_first_word got valid=%b data=%h want valid=1 data=3c", m_p_valid, m_p_data);
        end
      end
    end
    s_en = 1'b0;
    checks++;
    if (sb_q.size() == 0 || m_p_data !== sb_q[0] || m_p_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_hold got valid=%b data=%h want valid=1 data=3c", m_p_valid, m_p_data);
    end
    checks++;
    if (m_overflow !== 1'b1 || l_overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_overflow got msb=%b lsb=%b want 1", m_overflow, l_overflow);
    end
    @(negedge clk);
    wd += int'(m_word_done);
    checks++;
    if (wd !== 2) begin
      errors++; $display("FAIL b2b_word_done_count got %0d want 2", wd);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (m_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b want 0", m_overflow);
    end
    p_ready = 1'b1;
    checks++;
    if (sb_q.size() == 0 || m_p_data !== sb_q[0] || m_p_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_drain got valid=%b data=%h want valid=1 data=3c", m_p_valid, m_p_data);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
    checks++;
    if (m_p_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drained got valid=%b want 0", m_p_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    seq = 16'h3CF0;
    p_ready = 1'b0;
    sb_q.push_back(8'h3C);
    sb_q.push_back(8'hF0);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) begin
        // Drain word 1 in the same cycle word 2 completes.
        checks++;
        if (sb_q.size() == 0 || m_p_valid !== 1'b1 || m_p_data !== sb_q[0]) begin
          errors++; $display("FAIL b2b_ready_first got valid=%b data=%h want valid=1 data=3c", m_p_valid, m_p_data);
        end
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        p_ready = 1'b1;
      end
      drive_bit(seq[i]);
    end
    s_en    = 1'b0;
    p_ready = 1'b0;
    checks++;
    if (m_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_no_overflow got %b want 0", m_overflow);
    end
    checks++;
    if (sb_q.size() == 0 || m_p_valid !== 1'b1 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL b2b_ready_second got valid=%b data=%h want valid=1 data=f0", m_p_valid, m_p_data);
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0 || m_p_valid !== 1'b1 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL b2b_ready_stable got valid=%b data=%h want valid=1 data=f0", m_p_valid, m_p_data);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    p_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_p_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_drained got valid=%b want 0", m_p_valid);
    end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    p_ready = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    checks++;
    if (m_bit_cnt !== 3'd5) begin
      errors++; $display("FAIL abort_bitcnt_before got %0d want 5", m_bit_cnt);
    end
    s_en = 1'b0;
    @(negedge clk);
    checks++;
    if (m_frame_abort !== 1'b1 || m_bit_cnt !== 3'd0 || m_p_valid !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got abort=%b cnt=%0d valid=%b want 1/0/0", m_frame_abort, m_bit_cnt, m_p_valid);
    end
    @(negedge clk);
    checks++;
    if (m_frame_abort !== 1'b0 || m_word_done !== 1'b0) begin
      errors++; $display("FAIL abort_single got abort=%b done=%b want 0/0", m_frame_abort, m_word_done);
    end
    w = 8'h81;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    s_en = 1'b0;
    checks++;
    if (sb_q.size() == 0 || m_p_valid !== 1'b1 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL abort_next_word got valid=%b data=%h want valid=1 data=81", m_p_valid, m_p_data);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    checks++;
    if (l_p_data !== rev8(w)) begin
      errors++; $display("FAIL abort_next_lsb got %h want %h", l_p_data, rev8(w));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    p_ready = 1'b0;
    w = 8'h66;  // fills the output register, then discarded by reset
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    checks++;
    if (m_p_valid !== 1'b1 || m_bit_cnt !== 3'd4) begin
      errors++; $display("FAIL midrst_setup got valid=%b cnt=%0d want 1/4", m_p_valid, m_bit_cnt);
    end
    #2;
    s_en  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_p_data, m_p_valid, m_word_done, m_frame_abort, m_overflow, m_bit_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL midrst_async got %h/%b/%b/%b/%b/%0d want all zero",
               m_p_data, m_p_valid, m_word_done, m_frame_abort, m_overflow, m_bit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_frame_abort !== 1'b0 || m_word_done !== 1'b0 || m_p_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_no_pulse got abort=%b done=%b valid=%b want 0/0/0", m_frame_abort, m_word_done, m_p_valid);
    end
    p_ready = 1'b1;
    w = 8'h5A;
    sb_q.push_back(w);
    for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    s_en = 1'b0;
    checks++;
    if (sb_q.size() == 0 || m_p_valid !== 1'b1 || m_p_data !== sb_q[0]) begin
      errors++; $display("FAIL midrst_next_word got valid=%b data=%h want valid=1 data=5a", m_p_valid, m_p_data);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_lsb_first();
    test_back_to_back_overflow();
    test_back_to_back();
    test_abort();
    test_reset_midword();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty got %0d entries want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out front stage of the SIPO/PISO path.
- Assembles DATA_W serial bits, qualified by s_en, into one parallel word.
- Presents each completed word on a one-entry valid/ready output register to the downstream PISO/controller logic.
- Clears its bit count whenever s_en drops, consistent with the controller counter, and flags dropped or aborted frames.

Parameters:
- DATA_W, 8, parallel word width in bits; must be >= 2.
- MSB_FIRST, 1, 1: first serial bit lands in p_data[DATA_W-1]; 0: first bit lands in p_data[0].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_en  in  1  serial enable; a bit is sampled on every clk edge where s_en=1.
- s_data  in  1  serial data bit.
- p_data  out  DATA_W  parallel word held in the output register.
- p_valid  out  1  output register holds an unconsumed word.
- p_ready  in  1  downstream accepts; transfer occurs when p_valid & p_ready.
- word_done  out  1  one-cycle pulse in the cycle after the last bit of a word is sampled.
- frame_abort  out  1  one-cycle pulse when s_en drops with 1..DATA_W-1 bits collected.
- overflow  out  1  sticky; a completed word was dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- bit_cnt  out  $clog2(DATA_W)  current count of collected bits, for debug.

Behaviour:
- Reset (async, rst_n=0) forces the following, with all effects immediate:
  - p_data=0, p_valid=0, word_done=0, frame_abort=0, overflow=0, bit_cnt=0.
  - Shift register cleared; FSM in IDLE.
- FSM states:
  - IDLE: bit_cnt=0.
  - SHIFT: 1 <= bit_cnt <= DATA_W-1.
- IDLE, s_en=1: sample bit 0, bit_cnt<=1, go to SHIFT. For DATA_W=2 the next sampled bit completes the word.
- SHIFT, s_en=1: sample bit, bit_cnt<=bit_cnt+1.
  - When the sampled bit is bit DATA_W-1, the word completes: bit_cnt wraps to 0 and the FSM goes to IDLE.
  - A continuous s_en stream then restarts the next word on the next edge with no gap cycle.
- SHIFT, s_en=0:
  - Partial word discarded, bit_cnt<=0, go to IDLE.
  - frame_abort=1 for one cycle, starting the next cycle.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit into LSB of the shift register.
  - MSB_FIRST=0: shift right, new bit into MSB.
- Word completion at edge N, for the p_data/p_valid update:
  - Output register free (p_valid=0), or being drained this cycle (p_valid & p_ready): p_data<=assembled word and p_valid<=1 after edge N. Latency: the last serial bit is visible on p_data one cycle later.
  - Output register full and not draining (p_valid=1, p_ready=0): new word dropped, p_data unchanged, overflow<=1.
- word_done pulses on completion whether or not the word was dropped.
- Transfer without completion: p_valid<=0; p_data holds its last value.
- p_valid, once set, stays 1 with p_data stable until the transfer happens.
- ovf_clr=1 clears overflow. If ovf_clr coincides with a new drop, the set wins (overflow=1).
- s_data is don't-care when s_en=0.
- Reset asserted mid-word or with p_valid=1 discards everything, with no pulses.

Decomposition:
- Package sipo_pkg holds:
  - typedef enum logic {IDLE, SHIFT} sipo_state_t;
  - localparam DEF_DATA_W=8;
  - a function for bit-count width ($clog2 with floor of 1).
- Sub-module sipo_bit_counter: parameterised modulo-DATA_W counter with en/clear, outputs count and last (count==DATA_W-1 & en). It generalises the controller counter.
- Shift register, output register and flags live in the top level.

Test Plan:
- Reset then stream 0xA5 MSB-first with s_en held 8 cycles and p_ready=1:
  - p_data=8'hA5 and p_valid=1 one cycle after the 8th bit; word_done pulses once.
  - Transfer next cycle; p_valid=0.
- MSB_FIRST=0 instance, serial bits 1,0,1,0,0,1,0,1 → p_data=8'hA5.
- Two back-to-back words 0x3C then 0xF0 (16 continuous s_en cycles), p_ready=0:
  - p_data stays 8'h3C, overflow=1, word_done pulses twice.
  - ovf_clr for one cycle → overflow=0.
- Same back-to-back stream with p_ready=1 in the completion cycle of word 2 → no overflow; p_data=8'hF0 and p_valid stays 1.
- s_en high 5 cycles, then low:
  - frame_abort pulses once, bit_cnt=0, p_valid stays 0.
  - Next full word 0x81 is assembled correctly.
- Assert rst_n low after 4 bits and with p_valid=1:
  - All outputs go to 0 immediately.
  - After release, a full word 0x5A is delivered normally.
